scratchpad_read_responder: RTL and testbench

//  Memory-side responder for the 8-lane small-buffer read handshake (start_read / mem_offset / read_done / mem0..mem7).

---
 rtl/scratchpad_read_responder.sv | 188 ++++++++++++++++++
 tb/tb_scratchpad_read_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_read_responder.sv
// scratchpad_read_responder
// Memory-side responder for the 8-lane scratchpad read handshake. A request
// fetches 8 consecutive 128-bit lines from a fixed-latency synchronous RAM,
// one line per cycle, and presents them in parallel on mem0..mem7.
//
// Handshake: the requester raises start_read (with mem_offset) and keeps it
// high until it sees read_done. The offset is sampled only on the accepting
// edge in IDLE. read_done rises together with the last captured line and
// stays high while start_read is held; the first edge with start_read low
// clears read_done/busy and returns to IDLE. If start_read is already low
// when the request completes, read_done is a single-cycle pulse.
module scratchpad_read_responder #(
  parameter int ADDR_W      = 17,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_read,
  input  logic [31:0]       mem_offset,
  output logic              read_done,
  output logic              busy,
  output logic [127:0]      mem0,
  output logic [127:0]      mem1,
  output logic [127:0]      mem2,
  output logic [127:0]      mem3,
  output logic [127:0]      mem4,
  output logic [127:0]      mem5,
  output logic [127:0]      mem6,
  output logic [127:0]      mem7,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [127:0]      ram_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        beat_q, beat_d;

  // Valid/index pipe: stage 0 mirrors the strobe currently on the RAM port,
  // the last stage lines up with the cycle its data is on ram_rd_data.
  logic [RAM_LATENCY-1:0]      vld_q, vld_d;
  logic [RAM_LATENCY-1:0][2:0] idx_q, idx_d;

  logic [127:0] lane_q [8];
  logic [127:0] lane_d [8];

  logic       cap_vld;
  logic [2:0] cap_idx;
  logic       last_cap;

  // Offset bits below the line size and above the scratchpad are don't-care.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{mem_offset[31:ADDR_W+4], mem_offset[3:0]};

  assign cap_vld  = vld_q[RAM_LATENCY-1];
  assign cap_idx  = idx_q[RAM_LATENCY-1];
  assign last_cap = cap_vld && (cap_idx == 3'd7);

  // Next-state logic: accept, issue 8 beats, wait for the last capture, hold done.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          state_d = ST_ISSUE;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          addr_d  = mem_offset[ADDR_W+3:4];
          beat_d  = 3'd0;
        end
      end
      ST_ISSUE: begin
        if (beat_q == 3'd7) begin
          rd_en_d = 1'b0;
          // With a 1-cycle RAM the last capture lands on this same edge.
          if (last_cap) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          beat_d = beat_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (last_cap) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!start_read) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift the beat tags one stage per cycle alongside the RAM pipeline.
  always_comb begin
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = rd_en_d;
    idx_d[0] = beat_d;
    for (int k = 1; k < RAM_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
  end

  // Only the lane whose beat is arriving this cycle is updated.
  always_comb begin
    lane_d = lane_q;
    if (cap_vld) begin
      lane_d[cap_idx] = ram_rd_data;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  // Capture pipe and lane registers; reset drops any beats still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  assign read_done = done_q;
  assign busy      = busy_q;
  assign ram_rd_en = rd_en_q;
  assign ram_addr  = addr_q;
  assign mem0      = lane_q[0];
  assign mem1      = lane_q[1];
  assign mem2      = lane_q[2];
  assign mem3      = lane_q[3];
  assign mem4      = lane_q[4];
  assign mem5      = lane_q[5];
  assign mem6      = lane_q[6];
  assign mem7      = lane_q[7];

endmodule

// File: tb/tb_scratchpad_read_responder.sv
// Bench for scratchpad_read_responder: four instances with RAM latency 1..4,
// each behind its own RAM model that returns line n = {96'h0, n}.
module tb_scratchpad_read_responder;

  localparam int AW = 17;
  localparam int NI = 4;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_5A5A_A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_read_r [NI];
  logic [31:0] mem_offset_r [NI];
  wire          read_done_w   [NI];
  wire          busy_w        [NI];
  wire          ram_rd_en_w   [NI];
  wire [AW-1:0] ram_addr_w    [NI];
  wire [127:0]  ram_rd_data_w [NI];
  wire [127:0]  mem_w         [NI][8];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  function automatic logic [127:0] line_of(input logic [AW-1:0] a);
    return {96'h0, 15'h0, a};
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [31:0] off, input int i);
    int unsigned b;
    b = (off >> 4) % 32'd131072;
    return AW'((b + i) % 131072);
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] off, input int i);
    return line_of(exp_addr(off, i));
  endfunction

  // ---------------- RAM models + DUTs ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = g + 1;
    logic [AW-1:0] pa [3];
    logic          pe [3];
    always @(posedge clk) begin
      pa[0] <= ram_addr_w[g];
      pe[0] <= ram_rd_en_w[g];
      for (int k = 1; k < 3; k++) begin
        pa[k] <= pa[k-1];
        pe[k] <= pe[k-1];
      end
    end
    if (L == 1) begin : g_comb
      assign ram_rd_data_w[g] = ram_rd_en_w[g] ? line_of(ram_addr_w[g]) : JUNK;
    end else begin : g_reg
      assign ram_rd_data_w[g] = pe[L-2] ? line_of(pa[L-2]) : JUNK;
    end
    scratchpad_read_responder #(.ADDR_W(AW), .RAM_LATENCY(L)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_read  (start_read_r[g]),
      .mem_offset  (mem_offset_r[g]),
      .read_done   (read_done_w[g]),
      .busy        (busy_w[g]),
      .mem0        (mem_w[g][0]),
      .mem1        (mem_w[g][1]),
      .mem2        (mem_w[g][2]),
      .mem3        (mem_w[g][3]),
      .mem4        (mem_w[g][4]),
      .mem5        (mem_w[g][5]),
      .mem6        (mem_w[g][6]),
      .mem7        (mem_w[g][7]),
      .ram_rd_en   (ram_rd_en_w[g]),
      .ram_addr    (ram_addr_w[g]),
      .ram_rd_data (ram_rd_data_w[g])
    );
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input bit ok, input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit outs_zero(input int g);
    bit z;
    z = (read_done_w[g] === 1'b0) && (busy_w[g] === 1'b0) &&
        (ram_rd_en_w[g] === 1'b0) && (ram_addr_w[g] === '0);
    for (int i = 0; i < 8; i++) begin
      if (mem_w[g][i] !== 128'h0) z = 1'b0;
    end
    return z;
  endfunction

  // ---------------- driver: one full request on instance g ----------------
  // Called at a negedge. start_read is lowered after sample drop_at.
  task automatic do_request(input int g, input logic [31:0] off, input int drop_at);
    int lat, d, hi, last;
    logic [127:0] prev [8];
    bit ok_a, ok_r, ok_b, ok_m;
    string n_a, n_r, n_b, n_m;
    logic [127:0] ga, ea, gr, er, gb, eb, gm, em;
    lat = g + 1;
    d = 7 + lat;
    hi = (drop_at > d) ? drop_at : d;
    last = hi + 1;
    ok_a = 1'b1; ok_r = 1'b1; ok_b = 1'b1; ok_m = 1'b1;
    n_a = $sformatf("addr g%0d", g); n_r = $sformatf("read_done g%0d", g);
    n_b = $sformatf("busy g%0d", g); n_m = $sformatf("lanes g%0d", g);
    ga = '0; ea = '0; gr = '0; er = '0; gb = '0; eb = '0; gm = '0; em = '0;
    for (int i = 0; i < 8; i++) prev[i] = mem_w[g][i];
    start_read_r[g] = 1'b1;
    mem_offset_r[g] = off;
    for (int c = 0; c <= last; c++) begin
      logic [127:0] want;
      bit x_done, x_busy;
      @(negedge clk);
      x_done = (c >= d) && (c <= hi);
      x_busy = (c <= hi);
      if (c <= 7) begin
        if (ok_a && (ram_rd_en_w[g] !== 1'b1 || ram_addr_w[g] !== exp_addr(off, c))) begin
          ok_a = 1'b0; n_a = $sformatf("addr g%0d c%0d", g, c);
          ga = {ram_rd_en_w[g], ram_addr_w[g]}; ea = {1'b1, exp_addr(off, c)};
        end
      end else if (ok_a && ram_rd_en_w[g] !== 1'b0) begin
        ok_a = 1'b0; n_a = $sformatf("rd_en g%0d c%0d", g, c);
        ga = 128'(ram_rd_en_w[g]); ea = 128'h0;
      end
      if (ok_r && read_done_w[g] !== x_done) begin
        ok_r = 1'b0; n_r = $sformatf("read_done g%0d c%0d", g, c);
        gr = 128'(read_done_w[g]); er = 128'(x_done);
      end
      if (ok_b && busy_w[g] !== x_busy) begin
        ok_b = 1'b0; n_b = $sformatf("busy g%0d c%0d", g, c);
        gb = 128'(busy_w[g]); eb = 128'(x_busy);
      end
      for (int i = 0; i < 8; i++) begin
        want = (c >= i + lat) ? exp_line(off, i) : prev[i];
        if (ok_m && mem_w[g][i] !== want) begin
          ok_m = 1'b0; n_m = $sformatf("lane%0d g%0d c%0d", i, g, c);
          gm = mem_w[g][i]; em = want;
        end
      end
      if (c == drop_at) start_read_r[g] = 1'b0;
      if (c == 2) mem_offset_r[g] = $urandom();
    end
    check(ok_a, n_a, ga, ea);
    check(ok_r, n_r, gr, er);
    check(ok_b, n_b, gb, eb);
    check(ok_m, n_m, gm, em);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [31:0] off;
    int          drop_at;
    logic [31:0] exp_lane0;
    logic [31:0] exp_lane4;
  } vec_t;

  initial begin
    vec_t tbl [6];
    bit quiet;
    tbl[0] = '{32'h0000_0100, 13, 32'd16,     32'd20};
    tbl[1] = '{32'h001F_FFC0,  9, 32'd131068, 32'd0};
    tbl[2] = '{32'h0000_010F, 10, 32'd16,     32'd20};
    tbl[3] = '{32'h0000_0100,  3, 32'd16,     32'd20};
    tbl[4] = '{32'hFFFF_FFF0, 11, 32'd131071, 32'd3};
    tbl[5] = '{32'h0000_0000,  0, 32'd0,      32'd4};

    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_read_r[g] = 1'b0;
      mem_offset_r[g] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check(outs_zero(g), $sformatf("reset_state g%0d", g), 128'(!outs_zero(g)), 128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed table on the default-latency instance.
    for (int v = 0; v < 6; v++) begin
      do_request(1, tbl[v].off, tbl[v].drop_at);
      check(mem_w[1][0] === {96'h0, tbl[v].exp_lane0}, $sformatf("tbl%0d mem0", v),
            mem_w[1][0], {96'h0, tbl[v].exp_lane0});
      check(mem_w[1][4] === {96'h0, tbl[v].exp_lane4}, $sformatf("tbl%0d mem4", v),
            mem_w[1][4], {96'h0, tbl[v].exp_lane4});
    end

    // Reset in the middle of ISSUE, with beats still in the RAM pipeline.
    start_read_r[1] = 1'b1;
    mem_offset_r[1] = 32'h0000_0100;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start_read_r[1] = 1'b0;
    #1;
    check(outs_zero(1), "reset_mid_request", 128'(!outs_zero(1)), 128'h0);
    #1 rst = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!outs_zero(1)) quiet = 1'b0;
    end
    check(quiet, "post_reset_quiet", 128'(!quiet), 128'h0);
    do_request(1, 32'h0000_0200, 9);
    check(mem_w[1][0] === 128'd32, "mem0_after_reset", mem_w[1][0], 128'd32);

    // Randomized back-to-back requests at every RAM latency.
    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < 6; n++) begin
        do_request(g, $urandom(), $urandom_range(0, 14));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
